// File: rtl/node_position_streamer_pkg.sv
// Shared types and constants for the node-position streamer and its snapshot bank.
package node_position_streamer_pkg;

  localparam int COORD_W_DEF = 32;
  localparam int OVR_W       = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

  // Node i occupies bits [(i+1)*coord_w-1 : i*coord_w] of a packed position bus.
  function automatic int node_lsb(input int node, input int coord_w);
    return node * coord_w;
  endfunction

endpackage

// File: rtl/node_snapshot_bank.sv
// Frozen copy of every node's x/y position, loaded in one cycle, read one node at a time.
module node_snapshot_bank
  import node_position_streamer_pkg::*;
#(
  parameter int TOTAL_NODES = 20,
  parameter int COORD_W     = COORD_W_DEF,
  parameter int IDX_W       = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load,
  input  logic [TOTAL_NODES*COORD_W-1:0] nodes_x,
  input  logic [TOTAL_NODES*COORD_W-1:0] nodes_y,
  input  logic [IDX_W-1:0]               rd_index,
  output logic [COORD_W-1:0]             rd_x,
  output logic [COORD_W-1:0]             rd_y
);

  logic [COORD_W-1:0] snap_x [TOTAL_NODES];
  logic [COORD_W-1:0] snap_y [TOTAL_NODES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TOTAL_NODES; i++) begin
        snap_x[i] <= '0;
        snap_y[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < TOTAL_NODES; i++) begin
        snap_x[i] <= nodes_x[node_lsb(i, COORD_W) +: COORD_W];
        snap_y[i] <= nodes_y[node_lsb(i, COORD_W) +: COORD_W];
      end
    end
  end

  // Compare-based mux keeps out-of-range index values harmless and width-clean.
  always_comb begin
    rd_x = '0;
    rd_y = '0;
    for (int i = 0; i < TOTAL_NODES; i++) begin
      if (rd_index == IDX_W'(i)) begin
        rd_x = snap_x[i];
        rd_y = snap_y[i];
      end
    end
  end

endmodule

// File: rtl/node_position_streamer.sv
// Snapshots all rope node positions on a frame tick and streams them one node per beat.
module node_position_streamer
  import node_position_streamer_pkg::*;
#(
  parameter int TOTAL_NODES = 20,
  parameter int COORD_W     = COORD_W_DEF,
  parameter int IDX_W       = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [TOTAL_NODES*COORD_W-1:0] nodes_x,
  input  logic [TOTAL_NODES*COORD_W-1:0] nodes_y,
  input  logic                           frame_tick,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [COORD_W-1:0]             out_x,
  output logic [COORD_W-1:0]             out_y,
  output logic [IDX_W-1:0]               out_index,
  output logic                           out_first,
  output logic                           out_last,
  output logic                           busy,
  output logic [OVR_W-1:0]               overrun_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_NODES - 1);

  stream_state_t    state;
  logic [IDX_W-1:0] index;
  logic             streaming;
  logic             final_xfer;
  logic             load;

  assign streaming  = (state == STREAM);
  assign final_xfer = streaming && out_ready && (index == LAST_IDX);
  assign load       = frame_tick && (!streaming || final_xfer);

  node_snapshot_bank #(
    .TOTAL_NODES(TOTAL_NODES),
    .COORD_W    (COORD_W),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .nodes_x (nodes_x),
    .nodes_y (nodes_y),
    .rd_index(index),
    .rd_x    (out_x),
    .rd_y    (out_y)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      index         <= '0;
      overrun_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_tick) begin
            state <= STREAM;
            index <= '0;
          end
        end
        STREAM: begin
          // A tick is only accepted on the final handshake; anywhere else it is dropped.
          if (frame_tick && !final_xfer && overrun_count != '1)
            overrun_count <= overrun_count + OVR_W'(1);
          if (out_ready) begin
            if (index == LAST_IDX) begin
              index <= '0;
              if (!frame_tick) state <= IDLE;
            end else begin
              index <= index + IDX_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          index <= '0;
        end
      endcase
    end
  end

  assign out_valid = streaming;
  assign busy      = streaming;
  assign out_index = index;
  assign out_first = streaming && (index == '0);
  assign out_last  = streaming && (index == LAST_IDX);

  assert property (@(posedge clk) disable iff (!reset) index <= LAST_IDX);

endmodule

// File: tb/tb_node_position_streamer.sv
// Randomized self-checking bench for node_position_streamer against a frame-level model.
module tb_node_position_streamer;

  localparam int N  = 20;
  localparam int CW = 32;
  localparam int IW = 8;

  logic            clk;
  logic            reset;
  logic [N*CW-1:0] nodes_x;
  logic [N*CW-1:0] nodes_y;
  logic            frame_tick;
  logic            out_ready;
  logic            out_valid;
  logic [CW-1:0]   out_x;
  logic [CW-1:0]   out_y;
  logic [IW-1:0]   out_index;
  logic            out_first;
  logic            out_last;
  logic            busy;
  logic [15:0]     overrun_count;

  int tests = 0;
  int fails = 0;

  node_position_streamer #(.TOTAL_NODES(N), .COORD_W(CW), .IDX_W(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .nodes_x      (nodes_x),
    .nodes_y      (nodes_y),
    .frame_tick   (frame_tick),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_index    (out_index),
    .out_first    (out_first),
    .out_last     (out_last),
    .busy         (busy),
    .overrun_count(overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level model: is a frame in flight, which node is on offer, frozen copy, dropped ticks.
  bit          m_active;
  int          m_pos;
  logic [31:0] m_sx [N];
  logic [31:0] m_sy [N];
  int          m_ovr;

  function automatic void model_reset();
    m_active = 1'b0;
    m_pos    = 0;
    m_ovr    = 0;
    for (int i = 0; i < N; i++) begin
      m_sx[i] = '0;
      m_sy[i] = '0;
    end
  endfunction

  function automatic void model_capture();
    for (int i = 0; i < N; i++) begin
      m_sx[i] = nodes_x[i*CW +: CW];
      m_sy[i] = nodes_y[i*CW +: CW];
    end
  endfunction

  function automatic void model_edge(input logic tick, input logic rdy);
    bit last_handshake;
    last_handshake = m_active && rdy && (m_pos == N - 1);
    if (!m_active) begin
      if (tick) begin
        model_capture();
        m_active = 1'b1;
        m_pos    = 0;
      end
    end else begin
      if (tick && !last_handshake && m_ovr < 65535) m_ovr++;
      if (rdy) begin
        if (m_pos == N - 1) begin
          m_pos = 0;
          if (tick) model_capture();
          else m_active = 1'b0;
        end else begin
          m_pos++;
        end
      end
    end
  endfunction

  function automatic logic [91:0] exp_vec();
    logic v;
    v = m_active;
    return {v, v, v && (m_pos == 0), v && (m_pos == N - 1), 16'(m_ovr),
            v ? 8'(m_pos) : 8'h0, v ? m_sx[m_pos] : 32'h0, v ? m_sy[m_pos] : 32'h0};
  endfunction

  function automatic logic [91:0] obs_vec();
    return {out_valid, busy, out_first, out_last, overrun_count,
            out_valid ? out_index : 8'h0, out_valid ? out_x : 32'h0, out_valid ? out_y : 32'h0};
  endfunction

  task automatic clk_step(input logic tick, input logic rdy);
    frame_tick = tick;
    out_ready  = rdy;
    @(posedge clk);
    model_edge(tick, rdy);
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic set_pattern_bus();
    for (int i = 0; i < N; i++) begin
      nodes_x[i*CW +: CW] = 32'h100 + i;
      nodes_y[i*CW +: CW] = 32'h200 + i;
    end
  endtask

  task automatic set_random_bus();
    for (int i = 0; i < N; i++) begin
      nodes_x[i*CW +: CW] = $urandom;
      nodes_y[i*CW +: CW] = $urandom;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    #12;
    tests++;
    if ({out_valid, busy, out_first, out_last, out_index, out_x, out_y, overrun_count} !== '0)
      begin
        fails++;
        $display("[TB] FAIL reset_outputs: got v=%b b=%b f=%b l=%b i=%0d x=%h y=%h o=%0d, want all 0",
                 out_valid, busy, out_first, out_last, out_index, out_x, out_y, overrun_count);
      end
    @(negedge clk);
    reset = 1'b1;
    clk_step(1'b0, 1'b1);
    tests++;
    if (obs_vec() !== exp_vec()) begin
      fails++;
      $display("[TB] FAIL reset_idle: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_basic_frame();
    set_pattern_bus();
    clk_step(1'b1, 1'b1);
    for (int b = 0; b < N; b++) begin
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("[TB] FAIL basic_beat %0d: got %h want %h", b, obs_vec(), exp_vec());
      end
      tests++;
      if (out_x !== 32'h100 + b || out_y !== 32'h200 + b || out_index !== 8'(b) ||
          out_first !== (b == 0) || out_last !== (b == N - 1)) begin
        fails++;
        $display("[TB] FAIL basic_const %0d: got x=%h y=%h i=%0d f=%b l=%b want x=%h i=%0d",
                 b, out_x, out_y, out_index, out_first, out_last, 32'h100 + b, b);
      end
      clk_step(1'b0, 1'b1);
    end
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_end: got valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_coherence();
    set_pattern_bus();
    clk_step(1'b1, 1'b1);
    for (int i = 0; i < N; i++) nodes_x[i*CW +: CW] = 32'hDEAD;
    for (int b = 0; b < N; b++) begin
      tests++;
      if (out_x !== 32'h100 + b || obs_vec() !== exp_vec()) begin
        fails++;
        $display("[TB] FAIL coherence %0d: got x=%h want %h (vec %h vs %h)",
                 b, out_x, 32'h100 + b, obs_vec(), exp_vec());
      end
      clk_step(1'b0, 1'b1);
    end
  endtask

  task automatic test_backpressure();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   next_idx;
    next_idx = 0;
    set_random_bus();
    clk_step(1'b1, 1'b1);
    for (int c = 0; c < 4 * N && out_valid; c++) begin
      tests++;
      if (out_index !== 8'(next_idx)) begin
        fails++;
        $display("[TB] FAIL bp_order cycle %0d: got index %0d want %0d", c, out_index, next_idx);
      end
      if (pat[c % 4]) next_idx++;
      clk_step(1'b0, pat[c % 4]);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("[TB] FAIL bp_beat cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    tests++;
    if (next_idx != N || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bp_count: got %0d transfers valid=%b want %0d valid=0",
               next_idx, out_valid, N);
    end
  endtask

  task automatic test_overrun_back_to_back();
    int          ovr_start;
    logic [31:0] new_x0;
    logic [31:0] new_y0;
    ovr_start = m_ovr;
    set_random_bus();
    clk_step(1'b1, 1'b1);
    for (int b = 0; b < N; b++) begin
      if (b == N - 1) begin
        set_random_bus();
        new_x0 = nodes_x[CW-1:0];
        new_y0 = nodes_y[CW-1:0];
      end
      clk_step((b == 5) || (b == N - 1), 1'b1);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("[TB] FAIL ovr_beat %0d: got %h want %h", b, obs_vec(), exp_vec());
      end
      if (b == 5) begin
        tests++;
        if (overrun_count !== 16'(ovr_start + 1)) begin
          fails++;
          $display("[TB] FAIL ovr_count: got %0d want %0d", overrun_count, ovr_start + 1);
        end
      end
    end
    tests++;
    if (out_valid !== 1'b1 || out_index !== 8'd0 || out_x !== new_x0 || out_y !== new_y0 ||
        overrun_count !== 16'(ovr_start + 1)) begin
      fails++;
      $display("[TB] FAIL b2b_restart: got v=%b i=%0d x=%h y=%h o=%0d want 1 0 %h %h %0d",
               out_valid, out_index, out_x, out_y, overrun_count, new_x0, new_y0, ovr_start + 1);
    end
    for (int b = 0; b < N; b++) begin
      clk_step(1'b0, 1'b1);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("[TB] FAIL b2b_drain %0d: got %h want %h", b, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0) set_random_bus();
      clk_step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("[TB] FAIL random cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    for (int c = 0; c < N + 1; c++) clk_step(1'b0, 1'b1);
    tests++;
    if (obs_vec() !== exp_vec() || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL random_drain: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_midstream();
    set_random_bus();
    clk_step(1'b1, 1'b1);
    for (int b = 0; b < 7; b++) clk_step(1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || obs_vec() !== exp_vec()) begin
      fails++;
      $display("[TB] FAIL reset_async: got valid=%b busy=%b vec %h want %h",
               out_valid, busy, obs_vec(), exp_vec());
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      clk_step(1'b0, 1'b1);
      tests++;
      if (out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
        fails++;
        $display("[TB] FAIL reset_no_resume %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    set_random_bus();
    clk_step(1'b1, 1'b1);
    tests++;
    if (out_valid !== 1'b1 || out_index !== 8'd0 || obs_vec() !== exp_vec()) begin
      fails++;
      $display("[TB] FAIL reset_restart: got %h want %h", obs_vec(), exp_vec());
    end
    for (int c = 0; c < N; c++) clk_step(1'b0, 1'b1);
  endtask

  task automatic test_saturation();
    clk_step(1'b1, 1'b0);
    for (int c = 0; c < 65540; c++) clk_step(1'b1, 1'b0);
    tests++;
    if (overrun_count !== 16'hFFFF || obs_vec() !== exp_vec()) begin
      fails++;
      $display("[TB] FAIL saturation: got %h want overrun ffff (vec %h vs %h)",
               overrun_count, obs_vec(), exp_vec());
    end
    for (int c = 0; c < N; c++) clk_step(1'b0, 1'b1);
    tests++;
    if (out_valid !== 1'b0 || overrun_count !== 16'hFFFF) begin
      fails++;
      $display("[TB] FAIL saturation_hold: got valid=%b ovr=%h want 0 ffff", out_valid, overrun_count);
    end
  endtask

  initial begin
    reset      = 1'b0;
    nodes_x    = '0;
    nodes_y    = '0;
    frame_tick = 1'b0;
    out_ready  = 1'b0;
    test_reset();
    test_basic_frame();
    test_coherence();
    test_backpressure();
    test_overrun_back_to_back();
    test_random();
    test_reset_midstream();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
